// File: rtl/ex_stage_md.sv
// Execute stage: operand forwarding, ALU, branch/JALR target, iterative RV-M mul/div, owns EX/MEM.
// Latency: ALU ops register 1 edge after presentation; mul/div registers XLEN+2 edges after presentation.
// Backpressure: stall_e holds the front end for XLEN+1 cycles per mul/div while EX/MEM takes bubbles.
module ex_stage_md #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MD_ENABLE  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  valid_e,
  input  logic                  flush_e,
  input  logic                  regwrite_e,
  input  logic                  memwrite_e,
  input  logic                  jump_e,
  input  logic                  jalr_e,
  input  logic                  branch_e,
  input  logic                  alu_src_e,
  input  logic                  md_en_e,
  input  logic [1:0]            result_src_e,
  input  logic [3:0]            alu_control_e,
  input  logic [2:0]            md_op_e,
  input  logic [2:0]            branch_control_e,
  input  logic [1:0]            fwd_a_sel_e,
  input  logic [1:0]            fwd_b_sel_e,
  input  logic [XLEN-1:0]       rs1_data_e,
  input  logic [XLEN-1:0]       rs2_data_e,
  input  logic [XLEN-1:0]       fwd_mem_data,
  input  logic [XLEN-1:0]       fwd_wb_data,
  input  logic [XLEN-1:0]       immediate_e,
  input  logic [XLEN-1:0]       pc_e,
  input  logic [XLEN-1:0]       pc_plus_4_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  output logic                  stall_e,
  output logic                  pc_src_e,
  output logic [XLEN-1:0]       pc_target_e,
  output logic                  zero_flag,
  output logic                  branch_flag,
  output logic                  ex_mem_valid,
  output logic                  ex_mem_regwrite,
  output logic                  ex_mem_memwrite,
  output logic [1:0]            ex_mem_result_src,
  output logic [XLEN-1:0]       ex_mem_alu_result,
  output logic [XLEN-1:0]       ex_mem_writedata,
  output logic [XLEN-1:0]       ex_mem_pc_plus_4,
  output logic [REG_ADDR_W-1:0] ex_mem_rd
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_result, jalr_sum, md_result;
  logic [SHW-1:0]  shamt;

  md_state_t       state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc_hi, acc_lo, opnd;
  logic [2:0]      md_op;
  logic            neg, div0;

  logic            md_en, md_go;
  logic            a_signed, b_signed, sa, sb, neg_n;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   mul_sum, div_rs;
  logic            div_ge;
  logic [XLEN-1:0] div_rem;
  logic [2*XLEN-1:0] prod, prod_s;

  // Forwarding muxes for both source operands
  always_comb begin
    case (fwd_a_sel_e)
      2'b01:   fwd_a = fwd_mem_data;
      2'b10:   fwd_a = fwd_wb_data;
      default: fwd_a = rs1_data_e;
    endcase
    case (fwd_b_sel_e)
      2'b01:   fwd_b = fwd_mem_data;
      2'b10:   fwd_b = fwd_wb_data;
      default: fwd_b = rs2_data_e;
    endcase
  end

  assign op_b  = alu_src_e ? immediate_e : fwd_b;
  assign shamt = op_b[SHW-1:0];

  // Single-cycle ALU
  always_comb begin
    alu_result = '0;
    case (alu_control_e)
      4'd0:    alu_result = fwd_a + op_b;
      4'd1:    alu_result = fwd_a - op_b;
      4'd2:    alu_result = fwd_a & op_b;
      4'd3:    alu_result = fwd_a | op_b;
      4'd4:    alu_result = fwd_a ^ op_b;
      4'd5:    alu_result = fwd_a << shamt;
      4'd6:    alu_result = fwd_a >> shamt;
      4'd7:    alu_result = $unsigned($signed(fwd_a) >>> shamt);
      4'd8:    alu_result = XLEN'($signed(fwd_a) < $signed(op_b));
      4'd9:    alu_result = XLEN'(fwd_a < op_b);
      4'd10:   alu_result = op_b;
      default: alu_result = '0;
    endcase
  end

  assign zero_flag = (alu_result == '0);

  // Branch comparator always works on the register operands, never the immediate
  always_comb begin
    case (branch_control_e)
      3'd0:    branch_flag = (fwd_a == fwd_b);
      3'd1:    branch_flag = (fwd_a != fwd_b);
      3'd4:    branch_flag = ($signed(fwd_a) <  $signed(fwd_b));
      3'd5:    branch_flag = ($signed(fwd_a) >= $signed(fwd_b));
      3'd6:    branch_flag = (fwd_a <  fwd_b);
      3'd7:    branch_flag = (fwd_a >= fwd_b);
      default: branch_flag = 1'b0;
    endcase
  end

  assign jalr_sum    = fwd_a + immediate_e;
  assign pc_target_e = jalr_e ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0}) : (pc_e + immediate_e);
  assign pc_src_e    = valid_e & ~flush_e & ~stall_e & (jump_e | (branch_e & branch_flag));

  // Mul/div start and stall generation
  assign md_en   = md_en_e & (MD_ENABLE != 0);
  assign md_go   = (state == IDLE) & valid_e & md_en & ~flush_e;
  assign stall_e = md_go | (state == BUSY);

  // Operand signedness and magnitudes; the unit works on magnitudes and fixes sign at the end
  assign a_signed = (md_op_e == 3'd1) | (md_op_e == 3'd2) | (md_op_e == 3'd4) | (md_op_e == 3'd6);
  assign b_signed = (md_op_e == 3'd1) | (md_op_e == 3'd4) | (md_op_e == 3'd6);
  assign sa       = a_signed & fwd_a[XLEN-1];
  assign sb       = b_signed & fwd_b[XLEN-1];
  assign mag_a    = sa ? -fwd_a : fwd_a;
  assign mag_b    = sb ? -fwd_b : fwd_b;
  // Remainder takes the dividend's sign; products and quotients take the XOR
  assign neg_n    = (md_op_e[2] & md_op_e[1]) ? sa : (sa ^ sb);

  // One shift-add step and one restoring-subtract step
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign div_rs  = {acc_hi, acc_lo[XLEN-1]};
  assign div_ge  = (div_rs >= {1'b0, opnd});
  assign div_rem = XLEN'(div_rs - {1'b0, opnd});

  assign prod   = {acc_hi, acc_lo};
  assign prod_s = neg ? -prod : prod;

  // Final result selection with divide-by-zero quotient forced to all-ones
  always_comb begin
    case (md_op)
      3'd0:             md_result = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3: md_result = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:       md_result = div0 ? '1 : (neg ? -acc_lo : acc_lo);
      default:          md_result = neg ? -acc_hi : acc_hi;
    endcase
  end

  // Mul/div sequencer: latch in IDLE, XLEN iterations in BUSY, hand off result in DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      md_op  <= '0;
      neg    <= 1'b0;
      div0   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (md_go) begin
            md_op  <= md_op_e;
            neg    <= neg_n;
            div0   <= (fwd_b == '0);
            acc_hi <= '0;
            cnt    <= '0;
            acc_lo <= md_op_e[2] ? mag_a : mag_b;
            opnd   <= md_op_e[2] ? mag_b : mag_a;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (flush_e) begin
            state <= IDLE;
          end else begin
            if (md_op[2]) begin
              acc_hi <= div_ge ? div_rem : div_rs[XLEN-1:0];
              acc_lo <= {acc_lo[XLEN-2:0], div_ge};
            end else begin
              {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CW'(XLEN - 1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // EX/MEM register: bubble on stall or flush, otherwise capture ALU or mul/div result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_mem_valid      <= 1'b0;
      ex_mem_regwrite   <= 1'b0;
      ex_mem_memwrite   <= 1'b0;
      ex_mem_result_src <= '0;
      ex_mem_alu_result <= '0;
      ex_mem_writedata  <= '0;
      ex_mem_pc_plus_4  <= '0;
      ex_mem_rd         <= '0;
    end else if (stall_e || flush_e) begin
      ex_mem_valid    <= 1'b0;
      ex_mem_regwrite <= 1'b0;
      ex_mem_memwrite <= 1'b0;
    end else begin
      ex_mem_valid      <= valid_e;
      ex_mem_regwrite   <= regwrite_e & valid_e;
      ex_mem_memwrite   <= memwrite_e & valid_e;
      ex_mem_result_src <= result_src_e;
      ex_mem_alu_result <= (state == DONE) ? md_result : alu_result;
      ex_mem_writedata  <= fwd_b;
      ex_mem_pc_plus_4  <= pc_plus_4_e;
      ex_mem_rd         <= rd_e;
    end
  end

endmodule
